jingle_scheduler: RTL and testbench

- Sits between PS2_decoder and audio_send and sequences jingle playback.
- Key-press jingle requests are buffered in a small FIFO queue and issued to audio_send one at a time.
- Each issue waits for end-of-jingle, then a programmable silence gap, before the next issue.
- Supports flush/abort and reports queue occupancy and dropped requests.

---
 rtl/jingle_scheduler.sv | 144 ++++++++++++++
 tb/tb_jingle_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jingle_scheduler.sv
`timescale 1ns/1ps
// Purpose : queue PS/2 jingle requests and issue them to audio_send one at a time, with a silence gap between jingles.
// Latency : a request written at one edge is issued (jingle_num_val_o) right after the next edge; all outputs are registered.
// Backpressure : no ready signal. Requests are dropped (drop_o) when the queue is full, the number is invalid, or stop_i is high.
//
// Ports:
//   clk_i, rst_i              CLOCK_50 domain clock, synchronous active-high reset
//   req_num_i, req_val_i      jingle request from PS2_decoder (one-cycle strobe)
//   stop_i                    flush the queue and abort the jingle in progress
//   audio_ena_i               playback enable; requests still queue while low
//   play_done_i               end-of-jingle pulse from audio_send
//   jingle_num_o/_val_o       issued jingle number and its one-cycle strobe
//   abort_o                   one-cycle pulse telling audio_send to stop and clear the DAC
//   playing_o                 high while a jingle is playing
//   queue_cnt_o               queue occupancy, 0..QUEUE_DEPTH
//   drop_o                    one-cycle pulse for each rejected request
module jingle_scheduler #(
  parameter int JINGLE_CNT  = 8,
  parameter int NUM_W       = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int GAP_CYCLES  = 2400000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_W-1:0]               req_num_i,
  input  logic                           req_val_i,
  input  logic                           stop_i,
  input  logic                           audio_ena_i,
  input  logic                           play_done_i,
  output logic [NUM_W-1:0]               jingle_num_o,
  output logic                           jingle_num_val_o,
  output logic                           abort_o,
  output logic                           playing_o,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_cnt_o,
  output logic                           drop_o
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // +2 keeps the width at least 1 even when the gap is disabled
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);

  localparam logic [NUM_W:0]   JCNT     = (NUM_W+1)'(JINGLE_CNT);
  localparam logic [CNT_W-1:0] Q_FULL   = CNT_W'(QUEUE_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic [NUM_W-1:0] queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;

  // Full is judged on the registered occupancy, so a same-cycle pop does
  // not make room for the incoming request.
  assign push = req_val_i && !stop_i && ({1'b0, req_num_i} < JCNT) && (queue_cnt_o != Q_FULL);
  assign pop  = (state == IDLE) && (queue_cnt_o != '0) && audio_ena_i && !stop_i;

  // Storage carries no reset; the pointers and occupancy define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      queue_mem[wr_ptr] <= req_num_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      gap_cnt          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      queue_cnt_o      <= '0;
      jingle_num_o     <= '0;
      jingle_num_val_o <= 1'b0;
      abort_o          <= 1'b0;
      playing_o        <= 1'b0;
      drop_o           <= 1'b0;
    end else begin
      jingle_num_val_o <= 1'b0;
      abort_o          <= 1'b0;
      drop_o           <= req_val_i && !push;

      if (stop_i) begin
        state       <= IDLE;
        gap_cnt     <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        queue_cnt_o <= '0;
        playing_o   <= 1'b0;
        abort_o     <= (state == PLAY);
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          queue_cnt_o <= queue_cnt_o + 1'b1;
        end else if (pop && !push) begin
          queue_cnt_o <= queue_cnt_o - 1'b1;
        end

        case (state)
          IDLE: begin
            if (pop) begin
              jingle_num_o     <= queue_mem[rd_ptr];
              jingle_num_val_o <= 1'b1;
              playing_o        <= 1'b1;
              state            <= PLAY;
            end
          end
          PLAY: begin
            // audio_ena_i is deliberately ignored here: a started jingle finishes
            if (play_done_i) begin
              playing_o <= 1'b0;
              if (GAP_CYCLES == 0) begin
                state <= IDLE;
              end else begin
                state   <= GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jingle_scheduler.sv
`timescale 1ns/1ps
// Directed bench for jingle_scheduler with a scoreboard of expected issue numbers.
// JINGLE_CNT=7 so 0..6 are valid and 7 is invalid; gap of 4 cycles; depth 4.
module tb_jingle_scheduler;

  localparam int JC = 7;
  localparam int NW = 3;
  localparam int QD = 4;
  localparam int GC = 4;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic                 rst_i       = 1'b1;
  logic [NW-1:0]        req_num_i   = '0;
  logic                 req_val_i   = 1'b0;
  logic                 stop_i      = 1'b0;
  logic                 audio_ena_i = 1'b0;
  logic                 play_done_i = 1'b0;
  logic [NW-1:0]        jingle_num_o;
  logic                 jingle_num_val_o;
  logic                 abort_o;
  logic                 playing_o;
  logic [$clog2(QD):0]  queue_cnt_o;
  logic                 drop_o;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int n;

  jingle_scheduler #(
    .JINGLE_CNT (JC),
    .NUM_W      (NW),
    .QUEUE_DEPTH(QD),
    .GAP_CYCLES (GC)
  ) dut (
    .clk_i           (CLOCK_50),
    .rst_i           (rst_i),
    .req_num_i       (req_num_i),
    .req_val_i       (req_val_i),
    .stop_i          (stop_i),
    .audio_ena_i     (audio_ena_i),
    .play_done_i     (play_done_i),
    .jingle_num_o    (jingle_num_o),
    .jingle_num_val_o(jingle_num_val_o),
    .abort_o         (abort_o),
    .playing_o       (playing_o),
    .queue_cnt_o     (queue_cnt_o),
    .drop_o          (drop_o)
  );

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance past one rising edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push(input int num, input bit accept);
    req_num_i = NW'(num);
    req_val_i = 1'b1;
    if (accept) exp_q.push_back(num);
    tick();
    req_val_i = 1'b0;
    check("drop_after_req", int'(drop_o), accept ? 0 : 1);
  endtask

  task automatic done_pulse();
    play_done_i = 1'b1;
    tick();
    play_done_i = 1'b0;
  endtask

  task automatic wait_val(input int maxc, output int cnt);
    cnt = 0;
    while (jingle_num_val_o !== 1'b1 && cnt < maxc) begin
      tick();
      cnt++;
    end
  endtask

  // Scoreboard: every issue strobe must match the oldest accepted request.
  always @(negedge CLOCK_50) begin
    if (jingle_num_val_o === 1'b1) begin
      check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        check("sb_issue_num", int'(jingle_num_o), exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_num",     int'(jingle_num_o),     0);
    check("rst_val",     int'(jingle_num_val_o), 0);
    check("rst_abort",   int'(abort_o),          0);
    check("rst_playing", int'(playing_o),        0);
    check("rst_cnt",     int'(queue_cnt_o),      0);
    check("rst_drop",    int'(drop_o),           0);

    // Basic issue and gap timing, with stray done pulses in GAP and IDLE.
    audio_ena_i = 1'b1;
    push(5, 1);
    check("basic_cnt_after_push", int'(queue_cnt_o), 1);
    check("basic_no_val_yet", int'(jingle_num_val_o), 0);
    tick();
    check("basic_val", int'(jingle_num_val_o), 1);
    check("basic_playing", int'(playing_o), 1);
    check("basic_cnt_popped", int'(queue_cnt_o), 0);
    tick();
    check("basic_val_one_cycle", int'(jingle_num_val_o), 0);
    push(2, 1);
    check("play_cnt_queued", int'(queue_cnt_o), 1);
    audio_ena_i = 1'b0;
    repeat (3) tick();
    check("ena_low_no_abort", int'(playing_o), 1);
    audio_ena_i = 1'b1;
    done_pulse();
    check("gap_not_playing", int'(playing_o), 0);
    done_pulse();
    wait_val(20, n);
    check("gap_len", n, 4);
    repeat (2) tick();
    done_pulse();
    repeat (6) tick();
    done_pulse();
    check("idle_stray_done_playing", int'(playing_o), 0);
    check("idle_stray_done_val", int'(jingle_num_val_o), 0);
    push(4, 1);
    tick();
    check("idle_issue_latency", int'(jingle_num_val_o), 1);
    done_pulse();
    repeat (6) tick();

    // Ordering while disabled, then enabled.
    audio_ena_i = 1'b0;
    push(3, 1);
    push(1, 1);
    push(6, 1);
    check("order_cnt", int'(queue_cnt_o), 3);
    repeat (4) tick();
    check("order_disabled_hold", int'(queue_cnt_o), 3);
    audio_ena_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_val(20, n);
      check("order_latency", n, (k == 0) ? 1 : 5);
      repeat (2) tick();
      done_pulse();
    end
    repeat (8) tick();
    check("order_drained", int'(queue_cnt_o), 0);

    // Overflow, invalid number, full with same-cycle pop.
    audio_ena_i = 1'b0;
    push(7, 0);
    check("invalid_cnt", int'(queue_cnt_o), 0);
    for (int i = 0; i < 4; i++) push(i, 1);
    check("full_cnt", int'(queue_cnt_o), 4);
    push(4, 0);
    check("overflow_cnt", int'(queue_cnt_o), 4);
    audio_ena_i = 1'b1;
    push(5, 0);
    check("full_pop_cnt", int'(queue_cnt_o), 3);
    check("full_pop_val", int'(jingle_num_val_o), 1);

    // Stop during PLAY with entries queued.
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    exp_q.delete();
    check("stop_abort", int'(abort_o), 1);
    check("stop_cnt", int'(queue_cnt_o), 0);
    check("stop_playing", int'(playing_o), 0);
    tick();
    check("stop_abort_one_cycle", int'(abort_o), 0);
    wait_val(12, n);
    check("stop_no_issue", int'(jingle_num_val_o), 0);

    // Stop in IDLE with a push: drop, no abort.
    stop_i = 1'b1;
    req_num_i = 3'd1;
    req_val_i = 1'b1;
    tick();
    req_val_i = 1'b0;
    check("stop_push_drop", int'(drop_o), 1);
    check("stop_idle_no_abort", int'(abort_o), 0);
    check("stop_push_cnt", int'(queue_cnt_o), 0);
    stop_i = 1'b0;

    // Ten jingles through the depth-4 queue (pointers wrap).
    push(1, 1);
    push(4, 1);
    for (int i = 0; i < 10; i++) begin
      wait_val(20, n);
      check("wrap_issue", int'(jingle_num_val_o), 1);
      if (i + 2 < 10) push(((i + 2) * 3 + 1) % JC, 1);
      else tick();
      tick();
      done_pulse();
    end
    repeat (8) tick();
    check("wrap_drained", int'(queue_cnt_o), 0);

    // Reset during PLAY.
    push(4, 1);
    tick();
    check("rstplay_val", int'(jingle_num_val_o), 1);
    push(6, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    check("rstplay_num",     int'(jingle_num_o),     0);
    check("rstplay_val0",    int'(jingle_num_val_o), 0);
    check("rstplay_abort",   int'(abort_o),          0);
    check("rstplay_playing", int'(playing_o),        0);
    check("rstplay_cnt",     int'(queue_cnt_o),      0);
    tick();
    check("rstplay_abort_after", int'(abort_o), 0);
    push(5, 1);
    check("post_rst_no_val_yet", int'(jingle_num_val_o), 0);
    tick();
    check("post_rst_issue", int'(jingle_num_val_o), 1);
    repeat (2) tick();
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
